tdm_demux_4ch: RTL and testbench

//   Receive end of the 4-channel time-division link whose transmit side muxes

---
 rtl/tdm_demux_4ch.sv | 97 +++++++++
 tb/tb_tdm_demux_4ch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_4ch.sv
// Receive side of a 4-slot TDM link: tracks slot position from a frame-sync flag,
// collects beats into shadow registers and publishes whole frames with a valid strobe.
module tdm_demux_4ch #(
  parameter int WIDTH      = 1,
  parameter bit CHECK_SYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             out_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow_a, shadow_b, shadow_c;

  assign locked = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      slot      <= 2'd0;
      shadow_a  <= '0;
      shadow_b  <= '0;
      shadow_c  <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_d     <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (in_sync) begin
              shadow_a <= in_data;
              slot     <= 2'd1;
              state    <= RUN;
            end
          end
          RUN: begin
            if (slot == 2'd0) begin
              // Missing sync at a frame boundary means we lost alignment.
              if (in_sync || !CHECK_SYNC) begin
                shadow_a <= in_data;
                slot     <= 2'd1;
              end else begin
                sync_err <= 1'b1;
                slot     <= 2'd0;
                state    <= HUNT;
              end
            end else if (in_sync) begin
              // Early sync: drop the partial frame and restart on this beat.
              sync_err <= 1'b1;
              shadow_a <= in_data;
              slot     <= 2'd1;
            end else begin
              case (slot)
                2'd1: begin
                  shadow_b <= in_data;
                  slot     <= 2'd2;
                end
                2'd2: begin
                  shadow_c <= in_data;
                  slot     <= 2'd3;
                end
                default: begin
                  out_a     <= shadow_a;
                  out_b     <= shadow_b;
                  out_c     <= shadow_c;
                  out_d     <= in_data;
                  out_valid <= 1'b1;
                  slot      <= 2'd0;
                end
              endcase
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed vector table, hand sequences, and random beats
// checked against a queue-based frame model for both CHECK_SYNC settings.
module tb_tdm_demux_4ch;

  typedef logic [3:0] nib_t;
  typedef nib_t nq_t[$];

  typedef struct {
    bit   r, v, s;
    nib_t d;
    nib_t ea, eb, ec, ed;
    bit   eov, elk;
    logic [1:0] esl;
    bit   eerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0, in_valid = 1'b0, in_sync = 1'b0;
  nib_t in_data = '0;

  nib_t a1, b1, c1, d1, a0, b0, c0, d0;
  logic ov1, lk1, er1, ov0, lk0, er0;
  logic [1:0] sl1, sl0;

  int n_cmp = 0, n_bad = 0;

  // model state, index 0 = CHECK_SYNC=1, index 1 = CHECK_SYNC=0
  nq_t  fq0, fq1;
  bit   mlock[2], mov[2], merr[2];
  nib_t mout[2][4];

  vec_t tbl[21];

  always #5 clk = ~clk;

  tdm_demux_4ch #(.WIDTH(4), .CHECK_SYNC(1'b1)) u_cs1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
    .out_a(a1), .out_b(b1), .out_c(c1), .out_d(d1), .out_valid(ov1),
    .locked(lk1), .slot(sl1), .sync_err(er1));

  tdm_demux_4ch #(.WIDTH(4), .CHECK_SYNC(1'b0)) u_cs0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
    .out_a(a0), .out_b(b0), .out_c(c0), .out_d(d0), .out_valid(ov0),
    .locked(lk0), .slot(sl0), .sync_err(er0));

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Frame model: a partial frame is a queue of beats; its length is the next slot.
  task automatic model_step(bit r, bit v, nib_t d, bit s);
    for (int k = 0; k < 2; k++) begin
      nq_t q;
      bit  cs;
      cs = (k == 0);
      if (k == 0) q = fq0; else q = fq1;
      mov[k]  = 1'b0;
      merr[k] = 1'b0;
      if (r) begin
        q.delete();
        mlock[k] = 1'b0;
        for (int j = 0; j < 4; j++) mout[k][j] = '0;
      end else if (v) begin
        if (!mlock[k]) begin
          if (s) begin
            q.delete();
            q.push_back(d);
            mlock[k] = 1'b1;
          end
        end else if (q.size() == 0) begin
          if (s || !cs) q.push_back(d);
          else begin
            merr[k]  = 1'b1;
            mlock[k] = 1'b0;
          end
        end else if (s) begin
          merr[k] = 1'b1;
          q.delete();
          q.push_back(d);
        end else begin
          q.push_back(d);
          if (q.size() == 4) begin
            for (int j = 0; j < 4; j++) mout[k][j] = q[j];
            mov[k] = 1'b1;
            q.delete();
          end
        end
      end
      if (k == 0) fq0 = q; else fq1 = q;
    end
  endtask

  task automatic cmp_model();
    logic [1:0] s0, s1;
    s0 = 2'(fq0.size());
    s1 = 2'(fq1.size());
    chk("cs1_out", {a1, b1, c1, d1}, {mout[0][0], mout[0][1], mout[0][2], mout[0][3]});
    chk("cs1_flags", {11'd0, ov1, lk1, sl1, er1}, {11'd0, mov[0], mlock[0], s0, merr[0]});
    chk("cs0_out", {a0, b0, c0, d0}, {mout[1][0], mout[1][1], mout[1][2], mout[1][3]});
    chk("cs0_flags", {11'd0, ov0, lk0, sl0, er0}, {11'd0, mov[1], mlock[1], s1, merr[1]});
  endtask

  task automatic step(bit r, bit v, bit s, nib_t d);
    @(negedge clk);
    rst = r; in_valid = v; in_sync = s; in_data = d;
    @(posedge clk);
    #1;
    model_step(r, v, d, s);
    cmp_model();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    //              r  v  s  d      a  b  c  d  ov lk sl err
    tbl[0]  = '{1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[1]  = '{0, 1, 1, 4'd1,  0, 0, 0, 0, 0, 1, 2'd1, 0};
    tbl[2]  = '{0, 1, 0, 4'd2,  0, 0, 0, 0, 0, 1, 2'd2, 0};
    tbl[3]  = '{0, 1, 0, 4'd3,  0, 0, 0, 0, 0, 1, 2'd3, 0};
    tbl[4]  = '{0, 1, 0, 4'd4,  1, 2, 3, 4, 1, 1, 2'd0, 0};
    tbl[5]  = '{0, 0, 0, 4'd0,  1, 2, 3, 4, 0, 1, 2'd0, 0};
    tbl[6]  = '{0, 1, 1, 4'd9,  1, 2, 3, 4, 0, 1, 2'd1, 0};
    tbl[7]  = '{0, 1, 0, 4'd10, 1, 2, 3, 4, 0, 1, 2'd2, 0};
    tbl[8]  = '{0, 1, 1, 4'd11, 1, 2, 3, 4, 0, 1, 2'd1, 1};
    tbl[9]  = '{0, 1, 0, 4'd12, 1, 2, 3, 4, 0, 1, 2'd2, 0};
    tbl[10] = '{0, 1, 0, 4'd13, 1, 2, 3, 4, 0, 1, 2'd3, 0};
    tbl[11] = '{0, 1, 0, 4'd14, 11, 12, 13, 14, 1, 1, 2'd0, 0};
    tbl[12] = '{0, 1, 0, 4'd5,  11, 12, 13, 14, 0, 0, 2'd0, 1};
    tbl[13] = '{0, 1, 0, 4'd6,  11, 12, 13, 14, 0, 0, 2'd0, 0};
    tbl[14] = '{0, 0, 1, 4'd7,  11, 12, 13, 14, 0, 0, 2'd0, 0};
    tbl[15] = '{0, 1, 1, 4'd1,  11, 12, 13, 14, 0, 1, 2'd1, 0};
    tbl[16] = '{0, 1, 0, 4'd2,  11, 12, 13, 14, 0, 1, 2'd2, 0};
    tbl[17] = '{0, 1, 0, 4'd3,  11, 12, 13, 14, 0, 1, 2'd3, 0};
    tbl[18] = '{1, 1, 0, 4'd4,  0, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[19] = '{0, 1, 0, 4'd7,  0, 0, 0, 0, 0, 0, 2'd0, 0};
    tbl[20] = '{0, 1, 1, 4'd8,  0, 0, 0, 0, 0, 1, 2'd1, 0};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl%0d_out", i), {a1, b1, c1, d1},
          {tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed});
      chk($sformatf("tbl%0d_flags", i), {11'd0, ov1, lk1, sl1, er1},
          {11'd0, tbl[i].eov, tbl[i].elk, tbl[i].esl, tbl[i].eerr});
    end

    // Gapped frame: outputs hold until the 4th beat, strobe lasts one cycle.
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b1, 4'd1); idle(2);
    step(1'b0, 1'b1, 1'b0, 4'd2); idle(2);
    step(1'b0, 1'b1, 1'b0, 4'd3); idle(2);
    chk("gap_hold", {a1, b1, c1, d1}, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 4'd4);
    chk("gap_out", {a1, b1, c1, d1}, 16'h1234);
    chk("gap_ov", {15'd0, ov1}, 16'd1);
    idle(1);
    chk("gap_ov_drop", {15'd0, ov1}, 16'd0);

    // HUNT discards unsynced beats silently.
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'd7);
    step(1'b0, 1'b1, 1'b0, 4'd8);
    chk("hunt_quiet", {14'd0, lk1, er1}, 16'd0);
    step(1'b0, 1'b1, 1'b1, 4'd5);
    step(1'b0, 1'b1, 1'b0, 4'd6);
    step(1'b0, 1'b1, 1'b0, 4'd7);
    step(1'b0, 1'b1, 1'b0, 4'd8);
    chk("hunt_frame", {a1, b1, c1, d1}, 16'h5678);

    // Unsynced slot-0 beat: error for CHECK_SYNC=1, accepted for CHECK_SYNC=0.
    step(1'b0, 1'b1, 1'b0, 4'd9);
    chk("nosync_cs1", {11'd0, lk1, sl1, er1}, {11'd0, 1'b0, 2'd0, 1'b1});
    chk("nosync_cs0", {11'd0, lk0, sl0, er0}, {11'd0, 1'b1, 2'd1, 1'b0});
    step(1'b0, 1'b1, 1'b0, 4'd10);
    step(1'b0, 1'b1, 1'b0, 4'd11);
    step(1'b0, 1'b1, 1'b0, 4'd12);
    chk("nosync_cs0_out", {a0, b0, c0, d0, 15'd0, ov0}, {16'h9abc, 15'd0, 1'b1});
    chk("nosync_cs1_out", {a1, b1, c1, d1}, 16'h5678);

    // Random beats against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
